// File: rtl/fir_ctrl_fsm.sv
// rtl/fir_ctrl_fsm.sv - FIR accelerator job sequencer: clear, tap load, sample stream, drain, done
module fir_ctrl_fsm #(
    parameter int NB_TAPS   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] nb_samples_i,
    input  logic                 h_hs_i,
    input  logic                 x_hs_i,
    input  logic                 y_hs_i,
    output logic                 clear_o,
    output logic                 h_en_o,
    output logic                 x_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] y_cnt_o
);
    localparam int TapW = $clog2(NB_TAPS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_TAPS,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [TapW-1:0]      tap_cnt_q, tap_cnt_d;
    logic [CNT_WIDTH-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_WIDTH-1:0] y_cnt_q, y_cnt_d;
    logic [CNT_WIDTH-1:0] nb_samples_q, nb_samples_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            tap_cnt_q    <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            nb_samples_q <= '0;
        end else begin
            state_q      <= state_d;
            tap_cnt_q    <= tap_cnt_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            nb_samples_q <= nb_samples_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tap_cnt_d    = tap_cnt_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        nb_samples_d = nb_samples_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nb_samples_d = nb_samples_i;
                    tap_cnt_d    = '0;
                    x_cnt_d      = '0;
                    y_cnt_d      = '0;
                    // An empty job skips the clear and all stream phases entirely.
                    state_d      = (nb_samples_i != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: state_d = S_LOAD_TAPS;
            S_LOAD_TAPS: begin
                if (h_hs_i) begin
                    tap_cnt_d = tap_cnt_q + 1'b1;
                    if (tap_cnt_q == TapW'(NB_TAPS - 1)) state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (x_hs_i) begin
                    x_cnt_d = x_cnt_q + 1'b1;
                    if (x_cnt_q == nb_samples_q - 1'b1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (y_cnt_q == nb_samples_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Results can overtake the x stream, so y is counted in STREAM too; saturates at job size.
        if ((state_q == S_STREAM || state_q == S_DRAIN) && y_hs_i && (y_cnt_q != nb_samples_q)) begin
            y_cnt_d = y_cnt_q + 1'b1;
        end

        if (clear_i) begin
            state_d   = S_IDLE;
            tap_cnt_d = '0;
            x_cnt_d   = '0;
            y_cnt_d   = '0;
        end
    end

    assign clear_o = (state_q == S_CLEAR);
    assign h_en_o  = (state_q == S_LOAD_TAPS);
    assign x_en_o  = (state_q == S_STREAM);
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign y_cnt_o = y_cnt_q;

endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// tb/tb_fir_ctrl_fsm.sv - scoreboard bench for fir_ctrl_fsm with randomized stream handshakes
module tb_fir_ctrl_fsm;
    localparam int NB_TAPS   = 4;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [CNT_WIDTH-1:0] nb_samples_i = '0;
    logic                 h_hs_i = 1'b0;
    logic                 x_hs_i = 1'b0;
    logic                 y_hs_i = 1'b0;
    logic                 clear_o, h_en_o, x_en_o, busy_o, done_o;
    logic [CNT_WIDTH-1:0] y_cnt_o;

    fir_ctrl_fsm #(.NB_TAPS(NB_TAPS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .nb_samples_i(nb_samples_i), .h_hs_i(h_hs_i), .x_hs_i(x_hs_i), .y_hs_i(y_hs_i),
        .clear_o(clear_o), .h_en_o(h_en_o), .x_en_o(x_en_o), .busy_o(busy_o),
        .done_o(done_o), .y_cnt_o(y_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h_beats;
        int x_beats;
        int y_final;
        int clears;
        bit empty;
    } job_t;

    job_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_seen = 0;

    int   n_clr, n_en, n_h, n_x, last_y;
    bit   prev_done;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts admitted beats per job and scores each done_o against the queue.
    always @(negedge clk) begin
        if (!rst_ni || clear_i) begin
            n_clr = 0; n_en = 0; n_h = 0; n_x = 0; last_y = 0; prev_done = 0;
        end else begin
            if (prev_done) check("busy_after_done", int'(busy_o), 0);
            if (clear_o) n_clr++;
            if (h_en_o || x_en_o) n_en++;
            if (h_en_o && h_hs_i) n_h++;
            if (x_en_o && x_hs_i) n_x++;
            if (y_hs_i && busy_o && !done_o) last_y = cyc + 1;
            if (done_o) begin
                check("done_width", int'(prev_done), 0);
                check("busy_in_done", int'(busy_o), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    job_t e;
                    e = exp_q.pop_front();
                    check("h_beats", n_h, e.h_beats);
                    check("x_beats", n_x, e.x_beats);
                    check("y_cnt_o", int'(y_cnt_o), e.y_final);
                    check("clear_pulses", n_clr, e.clears);
                    if (e.empty) check("enables_in_empty_job", n_en, 0);
                    else         check("done_latency", cyc - last_y, 1);
                end
                done_seen++;
                n_clr = 0; n_en = 0; n_h = 0; n_x = 0;
            end
            prev_done = done_o;
        end
    end

    task automatic idle_inputs();
        start_i = 0; h_hs_i = 0; x_hs_i = 0; y_hs_i = 0; clear_i = 0;
    endtask

    // abort_x >= 0: assert clear_i once that many x beats have been admitted.
    task automatic run_job(input int nb, input int ydly, input bit spam, input int abort_x);
        int   due[$];
        int   x_acc;
        int   budget;
        int   dn0;
        job_t e;
        dn0 = done_seen;
        x_acc = 0;
        @(posedge clk); #2;
        start_i = 1;
        nb_samples_i = CNT_WIDTH'(nb);
        if (abort_x < 0) begin
            e.h_beats = (nb == 0) ? 0 : NB_TAPS;
            e.x_beats = nb;
            e.y_final = nb;
            e.clears  = (nb == 0) ? 0 : 1;
            e.empty   = (nb == 0);
            exp_q.push_back(e);
        end
        @(posedge clk); #2;
        budget = 0;
        while (done_seen == dn0 && budget < 3000) begin
            start_i = spam;
            if (spam) nb_samples_i = CNT_WIDTH'($urandom_range(0, 30));
            if (abort_x >= 0 && x_acc == abort_x) begin
                h_hs_i = 0; x_hs_i = 0; y_hs_i = 0; start_i = 0; clear_i = 1;
                @(posedge clk); #2;
                clear_i = 0;
                check("abort_busy", int'(busy_o), 0);
                check("abort_y_cnt", int'(y_cnt_o), 0);
                check("abort_x_en", int'(x_en_o), 0);
                repeat (5) begin
                    h_hs_i = 1'($urandom); x_hs_i = 1'($urandom);
                    @(posedge clk); #2;
                end
                check("abort_no_done", done_seen - dn0, 0);
                idle_inputs();
                return;
            end
            h_hs_i = 1'($urandom);
            x_hs_i = 1'($urandom);
            y_hs_i = 0;
            if (due.size() > 0 && due[0] <= cyc + 1) begin
                y_hs_i = 1;
                void'(due.pop_front());
            end
            if (x_en_o && x_hs_i) begin
                x_acc++;
                due.push_back(cyc + 1 + ydly);
            end
            @(posedge clk); #2;
            budget++;
        end
        if (done_seen == dn0) begin
            vectors++;
            miscompares++;
            $display("FAIL job_timeout: no done_o within %0d cycles for nb=%0d", budget, nb);
        end
        idle_inputs();
    endtask

    task automatic reset_mid_load();
        int budget;
        @(posedge clk); #2;
        start_i = 1;
        nb_samples_i = 6;
        @(posedge clk); #2;
        start_i = 0;
        budget = 0;
        while (!h_en_o && budget < 10) begin
            @(posedge clk); #2;
            budget++;
        end
        check("reached_load_taps", int'(h_en_o), 1);
        h_hs_i = 1;
        @(posedge clk); #3;
        h_hs_i = 0;
        rst_ni = 0;
        #1;
        check("rst_outputs_async", int'({clear_o, h_en_o, x_en_o, busy_o, done_o}), 0);
        check("rst_y_cnt_async", int'(y_cnt_o), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1;
        for (int i = 0; i < 6; i++) begin
            h_hs_i = 1'($urandom); x_hs_i = 1'($urandom); y_hs_i = 1'($urandom);
            @(posedge clk); #2;
            check("idle_spurious_busy", int'(busy_o), 0);
            check("idle_spurious_y_cnt", int'(y_cnt_o), 0);
        end
        idle_inputs();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", int'({clear_o, h_en_o, x_en_o, busy_o, done_o}), 0);
        check("reset_y_cnt", int'(y_cnt_o), 0);
        rst_ni = 1;

        run_job(8, 1, 0, -1);
        run_job(0, 1, 0, -1);
        run_job(5, 20, 0, -1);
        run_job(7, 2, 1, -1);
        run_job(8, 1, 0, 3);
        run_job(8, 1, 0, -1);
        reset_mid_load();
        run_job(4, 1, 0, -1);
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, 12)), int'($urandom_range(1, 6)), 1'($urandom), -1);
        end
        run_job(1, 1, 0, -1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
